seed_load_ctrl: RTL and testbench
=================================

Name: seed_load_ctrl

Overview:
- Sequences the write port of the 128x32 seed RAM.
- Accepts one 3072-bit Toeplitz seed as 96 32-bit words from a host stream and writes them to consecutive RAM addresses.
- Once the last write has retired, it arms the seed reader and waits for shift_ack before reporting the seed loaded.
- Sits beside the seed reader inside the seed-creation block and replaces the tied-off write port (wren=0).

Parameters:
- SEED_WORDS, 96, words per seed (3072/32).
- DATA_W, 32, RAM word width.
- ADDR_W, 7, RAM address width.
- BASE_ADDR, 0, first RAM address of the seed image.

Ports:
- clk_in  in  1  system clock, all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- load_start  in  1  request a new seed load; single-cycle pulse.
- load_abort  in  1  abandon the load in progress.
- wr_data  in  DATA_W  host seed word.
- wr_valid  in  1  wr_data valid.
- wr_ready  out  1  controller accepts wr_data this cycle.
- rd_busy  in  1  seed reader is mid-read (its ram_read/shift_en activity).
- rd_start  out  1  one-cycle pulse telling the reader to fetch the seed.
- shift_ack  in  1  reader/consumer has taken the seed.
- ram_wren  out  1  seed RAM write enable.
- ram_wraddr  out  ADDR_W  seed RAM write address.
- ram_wdata  out  DATA_W  seed RAM write data.
- seed_loaded  out  1  a complete seed has been written and acknowledged.
- seed_xor  out  DATA_W  XOR of all words accepted in the current or last load.
- err_busy  out  1  sticky; load_start arrived while not IDLE.

Behaviour:
- Reset: all outputs 0. State IDLE, word counter 0.
- States: IDLE, LOAD, FLUSH, ARM, WAIT_ACK.
- IDLE:
  - On load_start, go to LOAD.
  - On entering LOAD: clear the counter, seed_xor and seed_loaded; clear err_busy.
- LOAD:
  - wr_ready = 1 combinationally while in LOAD and count < SEED_WORDS.
  - A beat is accepted when wr_valid & wr_ready.
  - Accept at cycle t: at t+1, ram_wren=1, ram_wraddr=BASE_ADDR+count (mod 2^ADDR_W), ram_wdata=word. count increments. seed_xor ^= word.
  - ram_wren is 0 on every cycle with no accept. Write latency is exactly 1 cycle.
  - Acceptance of beat SEED_WORDS-1 moves the FSM to FLUSH; wr_ready drops the cycle after that accept.
- FLUSH: one cycle. The last registered write is presented here. Go to ARM.
- ARM:
  - Wait while rd_busy=1.
  - First cycle with rd_busy=0: rd_start=1 for exactly one cycle, then go to WAIT_ACK.
- WAIT_ACK:
  - On shift_ack, set seed_loaded=1 and go to IDLE.
  - seed_loaded holds until the next accepted load_start.
- load_abort:
  - In LOAD, FLUSH or ARM: go to IDLE next cycle and keep seed_loaded=0.
  - An accept in the same cycle as load_abort is still written (the write already issued completes); no further beats are accepted.
  - Ignored in IDLE and WAIT_ACK.
- load_start when state != IDLE: ignored; err_busy=1.
- Simultaneous load_start and load_abort in IDLE: load_start wins.
- shift_ack outside WAIT_ACK: ignored.
- Asserting rst mid-load: immediate return to reset values. RAM contents are undefined from the system's view; seed_loaded=0.
- The RAM write address never exceeds BASE_ADDR+SEED_WORDS-1. BASE_ADDR+SEED_WORDS must be <= 2^ADDR_W; this is checked at elaboration.

Decomposition:
- Shared package holds:
  - SEED_BITS=3072, SEED_WORDS=96, DATA_W=32, ADDR_W=7.
  - FSM state encoding (IDLE=0, LOAD=1, FLUSH=2, ARM=3, WAIT_ACK=4).
- No sub-module is required.
- The registered RAM write stage (wren/addr/data flops) may be factored as seed_ram_wr_stage if reused by a future loader.

Test Plan:
- Full load, reader idle: pulse load_start, stream words 0x00000000..0x0000005F back-to-back.
  - ram_wren high for 96 consecutive cycles, addresses 0..95, each data value equal to its address.
  - FLUSH, then rd_start pulses once, 2 cycles after the last accept.
  - shift_ack sets seed_loaded=1 and seed_xor=0x00000000.
- Throttled host: wr_valid toggles every other cycle.
  - ram_wren only follows accepted beats; still 96 writes in address order; wr_ready=0 after the 96th beat.
- Reader busy: hold rd_busy=1 for 20 cycles after FLUSH.
  - rd_start stays low throughout and fires the cycle rd_busy falls.
- Abort at word 40: assert load_abort.
  - Exactly 41 writes (addresses 0..40), state IDLE, seed_loaded=0, no rd_start.
- Busy error: load_start during LOAD.
  - err_busy=1, load continues unaffected; err_busy clears on the next load_start accepted in IDLE.
- Async reset at word 50: rst asserted with no clock edge.
  - All outputs 0 immediately.
  - A subsequent load starts again at address BASE_ADDR.

Source files
------------

// File: rtl/seed_load_ctrl_pkg.sv
// Shared constants and FSM encoding for the seed RAM write-side loader.
package seed_load_ctrl_pkg;

  localparam int unsigned SEED_BITS  = 3072;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned SEED_WORDS = SEED_BITS / DATA_W;
  localparam int unsigned ADDR_W     = 7;
  localparam int unsigned BASE_ADDR  = 0;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_FLUSH    = 3'd2,
    ST_ARM      = 3'd3,
    ST_WAIT_ACK = 3'd4
  } state_e;

endpackage

// File: rtl/seed_ram_wr_stage.sv
// Registered seed RAM write port: one-cycle write latency from request to RAM pins.
module seed_ram_wr_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 7
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              wr_en_c,
  input  logic [ADDR_W-1:0] wr_addr_c,
  input  logic [DATA_W-1:0] wr_data_c,
  output logic              ram_wren,
  output logic [ADDR_W-1:0] ram_wraddr,
  output logic [DATA_W-1:0] ram_wdata
);

  logic              wren_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;

  // Address/data only move on a write to keep the RAM pins quiet otherwise.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      wren_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      wren_q <= wr_en_c;
      if (wr_en_c) begin
        addr_q <= wr_addr_c;
        data_q <= wr_data_c;
      end
    end
  end

  assign ram_wren   = wren_q;
  assign ram_wraddr = addr_q;
  assign ram_wdata  = data_q;

endmodule

// File: rtl/seed_load_ctrl.sv
// Seed RAM loader: streams one Toeplitz seed into the RAM, then arms the seed
// reader and waits for the consumer's acknowledge.
module seed_load_ctrl #(
  parameter int unsigned SEED_WORDS = seed_load_ctrl_pkg::SEED_WORDS,
  parameter int unsigned DATA_W     = seed_load_ctrl_pkg::DATA_W,
  parameter int unsigned ADDR_W     = seed_load_ctrl_pkg::ADDR_W,
  parameter int unsigned BASE_ADDR  = seed_load_ctrl_pkg::BASE_ADDR
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              load_start,
  input  logic              load_abort,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic              rd_busy,
  output logic              rd_start,
  input  logic              shift_ack,
  output logic              ram_wren,
  output logic [ADDR_W-1:0] ram_wraddr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              seed_loaded,
  output logic [DATA_W-1:0] seed_xor,
  output logic              err_busy
);

  import seed_load_ctrl_pkg::*;

  localparam int unsigned CNT_W = $clog2(SEED_WORDS + 1);

  generate
    if (BASE_ADDR + SEED_WORDS > 2 ** ADDR_W) begin : g_addr_range_chk
      $error("seed image does not fit in the RAM address space");
    end
  endgenerate

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] xor_q, xor_d;
  logic              loaded_q, loaded_d;
  logic              err_q, err_d;
  logic              accept_c;
  logic [ADDR_W-1:0] wr_addr_c;

  assign wr_ready  = (state_q == ST_LOAD) && (cnt_q < CNT_W'(SEED_WORDS));
  assign accept_c  = wr_ready && wr_valid;
  assign wr_addr_c = ADDR_W'(BASE_ADDR) + ADDR_W'(cnt_q);

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      xor_q    <= '0;
      loaded_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      xor_q    <= xor_d;
      loaded_q <= loaded_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    xor_d    = xor_q;
    loaded_d = loaded_q;
    err_d    = err_q;
    rd_start = 1'b0;

    if (load_start && (state_q != ST_IDLE)) begin
      err_d = 1'b1;
    end

    // A beat accepted alongside an abort still counts and is still written.
    if (accept_c) begin
      cnt_d = cnt_q + CNT_W'(1);
      xor_d = xor_q ^ wr_data;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (load_start) begin
          state_d  = ST_LOAD;
          cnt_d    = '0;
          xor_d    = '0;
          loaded_d = 1'b0;
          err_d    = 1'b0;
        end
      end
      ST_LOAD: begin
        if (load_abort) begin
          state_d  = ST_IDLE;
          loaded_d = 1'b0;
        end else if (accept_c && (cnt_q == CNT_W'(SEED_WORDS - 1))) begin
          state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        state_d = load_abort ? ST_IDLE : ST_ARM;
      end
      ST_ARM: begin
        if (load_abort) begin
          state_d = ST_IDLE;
        end else if (!rd_busy) begin
          rd_start = 1'b1;
          state_d  = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        if (shift_ack) begin
          loaded_d = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  seed_ram_wr_stage #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_wr_stage (
    .clk_in     (clk_in),
    .rst        (rst),
    .wr_en_c    (accept_c),
    .wr_addr_c  (wr_addr_c),
    .wr_data_c  (wr_data),
    .ram_wren   (ram_wren),
    .ram_wraddr (ram_wraddr),
    .ram_wdata  (ram_wdata)
  );

  assign seed_loaded = loaded_q;
  assign seed_xor    = xor_q;
  assign err_busy    = err_q;

endmodule

// File: tb/tb_seed_load_ctrl.sv
// Self-checking bench for seed_load_ctrl: vector table, directed corner
// sequences and random traffic against a behavioural loader model.
module tb_seed_load_ctrl;

  localparam int unsigned SW   = 96;
  localparam int unsigned AW   = 7;
  localparam int unsigned BASE = 0;

  logic        clk_in = 1'b0;
  logic        rst;
  logic        load_start, load_abort, wr_valid, rd_busy, shift_ack;
  logic [31:0] wr_data;
  logic        wr_ready, rd_start, ram_wren, seed_loaded, err_busy;
  logic [6:0]  ram_wraddr;
  logic [31:0] ram_wdata, seed_xor;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always #5 clk_in = ~clk_in;

  seed_load_ctrl dut (
    .clk_in      (clk_in),
    .rst         (rst),
    .load_start  (load_start),
    .load_abort  (load_abort),
    .wr_data     (wr_data),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .rd_busy     (rd_busy),
    .rd_start    (rd_start),
    .shift_ack   (shift_ack),
    .ram_wren    (ram_wren),
    .ram_wraddr  (ram_wraddr),
    .ram_wdata   (ram_wdata),
    .seed_loaded (seed_loaded),
    .seed_xor    (seed_xor),
    .err_busy    (err_busy)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural model: loader phase flags plus the observable registers.
  bit          m_in_load, m_flush, m_arm, m_wait;
  int          m_beats;
  bit          m_wren;
  int          m_addr;
  logic [31:0] m_data, m_xor;
  bit          m_loaded, m_err;

  function automatic void model_reset();
    m_in_load = 0; m_flush = 0; m_arm = 0; m_wait = 0;
    m_beats = 0; m_wren = 0; m_addr = 0; m_data = '0; m_xor = '0;
    m_loaded = 0; m_err = 0;
  endfunction

  function automatic void model_edge();
    bit idle;
    bit acc;
    idle = !(m_in_load || m_flush || m_arm || m_wait);
    acc  = m_in_load && (m_beats < SW) && wr_valid;
    m_wren = acc;
    if (acc) begin
      m_addr = (BASE + m_beats) % (1 << AW);
      m_data = wr_data;
      m_xor  = m_xor ^ wr_data;
      m_beats++;
    end
    if (load_start && !idle) m_err = 1;
    if (idle) begin
      if (load_start) begin
        m_in_load = 1; m_beats = 0; m_xor = '0; m_loaded = 0; m_err = 0;
      end
    end else if (m_in_load) begin
      if (load_abort) m_in_load = 0;
      else if (m_beats == SW) begin m_in_load = 0; m_flush = 1; end
    end else if (m_flush) begin
      m_flush = 0;
      m_arm   = !load_abort;
    end else if (m_arm) begin
      if (load_abort) m_arm = 0;
      else if (!rd_busy) begin m_arm = 0; m_wait = 1; end
    end else if (m_wait && shift_ack) begin
      m_wait = 0; m_loaded = 1;
    end
  endfunction

  int          wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          rs_cyc_q[$];
  int          last_acc_cyc;
  bit          acc_seen;

  function automatic void clear_logs();
    wr_addr_q.delete(); wr_data_q.delete(); rs_cyc_q.delete();
  endfunction

  function automatic int bad_writes();
    int n = 0;
    foreach (wr_addr_q[i]) begin
      if (wr_addr_q[i] != int'(BASE) + i || wr_data_q[i] != 32'(i)) n++;
    end
    return n;
  endfunction

  task automatic run_cycle(input bit ls, input bit ab, input bit v,
                           input logic [31:0] d, input bit busy, input bit ack);
    load_start = ls; load_abort = ab; wr_valid = v; wr_data = d;
    rd_busy = busy; shift_ack = ack;
    @(negedge clk_in);
    check("wr_ready", 64'(wr_ready), 64'(m_in_load && (m_beats < SW)));
    check("rd_start", 64'(rd_start), 64'(m_arm && !busy && !ab));
    check("ram_wren", 64'(ram_wren), 64'(m_wren));
    if (m_wren) begin
      check("ram_wraddr", 64'(ram_wraddr), 64'(m_addr));
      check("ram_wdata", 64'(ram_wdata), 64'(m_data));
    end
    check("seed_loaded", 64'(seed_loaded), 64'(m_loaded));
    check("seed_xor", 64'(seed_xor), 64'(m_xor));
    check("err_busy", 64'(err_busy), 64'(m_err));
    acc_seen = wr_ready && wr_valid;
    if (acc_seen) last_acc_cyc = cyc;
    if (ram_wren) begin
      wr_addr_q.push_back(int'(ram_wraddr));
      wr_data_q.push_back(ram_wdata);
    end
    if (rd_start) rs_cyc_q.push_back(cyc);
    @(posedge clk_in);
    model_edge();
    cyc++;
    #1;
  endtask

  // Streams words 0..n-1; abort_at >= 0 raises load_abort with that beat.
  task automatic feed(input int n, input bit throttle, input int abort_at);
    int i;
    int t;
    bit v;
    bit ab;
    i = 0;
    t = 0;
    ab = 0;
    while (i < n && t < 1000 && !ab) begin
      v  = throttle ? (t % 2 == 0) : 1'b1;
      ab = (i == abort_at) && v;
      run_cycle(1'b0, ab, v, 32'(i), 1'b0, 1'b0);
      if (acc_seen) i++;
      t++;
    end
    if (i < n && !ab) begin
      checks++;
      failures++;
      $display("FAIL feed_timeout: accepted %0d words, required %0d", i, n);
    end
  endtask

  typedef struct {
    bit          ls, ab, v;
    logic [31:0] d;
    bit          rdy, wren;
    logic [6:0]  addr;
    logic [31:0] wdata, xr;
    bit          err;
  } vec_t;

  vec_t tbl[11];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] act;
    logic [63:0] exp;
    int          acc_end;
    bit          busy;

    tbl[0]  = '{0, 0, 0, 32'h00, 0, 0, 7'd0, 32'h00, 32'h00, 0};
    tbl[1]  = '{1, 0, 0, 32'h00, 0, 0, 7'd0, 32'h00, 32'h00, 0};
    tbl[2]  = '{0, 0, 1, 32'h11, 1, 0, 7'd0, 32'h00, 32'h00, 0};
    tbl[3]  = '{1, 0, 1, 32'h22, 1, 1, 7'd0, 32'h11, 32'h11, 0};
    tbl[4]  = '{0, 0, 0, 32'h00, 1, 1, 7'd1, 32'h22, 32'h33, 1};
    tbl[5]  = '{0, 1, 1, 32'h44, 1, 0, 7'd0, 32'h00, 32'h33, 1};
    tbl[6]  = '{0, 0, 0, 32'h00, 0, 1, 7'd2, 32'h44, 32'h77, 1};
    tbl[7]  = '{1, 1, 0, 32'h00, 0, 0, 7'd0, 32'h00, 32'h77, 1};
    tbl[8]  = '{0, 0, 0, 32'h00, 1, 0, 7'd0, 32'h00, 32'h00, 0};
    tbl[9]  = '{0, 1, 0, 32'h00, 1, 0, 7'd0, 32'h00, 32'h00, 0};
    tbl[10] = '{0, 0, 0, 32'h00, 0, 0, 7'd0, 32'h00, 32'h00, 0};

    rst = 1'b1;
    load_start = 0; load_abort = 0; wr_valid = 0; wr_data = '0;
    rd_busy = 0; shift_ack = 0;
    model_reset();
    repeat (2) @(posedge clk_in);
    #1;
    check("reset_ctrl", 64'({wr_ready, rd_start, ram_wren, seed_loaded, err_busy, ram_wraddr}), 64'(0));
    check("reset_wdata", 64'(ram_wdata), 64'(0));
    check("reset_xor", 64'(seed_xor), 64'(0));
    rst = 1'b0;

    // Vector table: start, busy error, abort with a same-cycle beat, start/abort tie.
    for (int i = 0; i < 11; i++) begin
      load_start = tbl[i].ls; load_abort = tbl[i].ab;
      wr_valid = tbl[i].v; wr_data = tbl[i].d;
      rd_busy = 0; shift_ack = 0;
      @(negedge clk_in);
      act = {wr_ready, ram_wren, (ram_wren ? ram_wraddr : 7'd0),
             (ram_wren ? ram_wdata : 32'd0), err_busy, rd_start, seed_loaded};
      exp = {tbl[i].rdy, tbl[i].wren, tbl[i].addr, tbl[i].wdata, tbl[i].err, 1'b0, 1'b0};
      check($sformatf("vec%0d", i), act, exp);
      check($sformatf("vec%0d_xor", i), 64'(seed_xor), 64'(tbl[i].xr));
      @(posedge clk_in);
      model_edge();
      cyc++;
      #1;
    end

    // Full load, reader idle.
    clear_logs();
    run_cycle(1, 0, 0, 0, 0, 0);
    feed(SW, 0, -1);
    acc_end = last_acc_cyc;
    run_cycle(0, 0, 0, 0, 0, 0);
    run_cycle(0, 0, 0, 0, 0, 0);
    run_cycle(0, 0, 0, 0, 0, 1);
    check("full_nwrites", 64'(wr_addr_q.size()), 64'(96));
    check("full_order", 64'(bad_writes()), 64'(0));
    check("full_rdstart_n", 64'(rs_cyc_q.size()), 64'(1));
    if (rs_cyc_q.size() > 0) check("full_rdstart_lat", 64'(rs_cyc_q[0] - acc_end), 64'(2));
    check("full_loaded", 64'(seed_loaded), 64'(1));
    check("full_xor", 64'(seed_xor), 64'(0));
    check("full_ready_low", 64'(wr_ready), 64'(0));

    // Throttled host, then reader busy for 20 cycles after FLUSH.
    clear_logs();
    run_cycle(1, 0, 0, 0, 0, 0);
    feed(SW, 1, -1);
    run_cycle(0, 0, 1, 0, 0, 0);
    check("thr_ready_low", 64'(wr_ready), 64'(0));
    check("thr_nwrites", 64'(wr_addr_q.size()), 64'(96));
    check("thr_order", 64'(bad_writes()), 64'(0));
    repeat (20) run_cycle(0, 0, 0, 0, 1, 0);
    check("busy_no_rdstart", 64'(rs_cyc_q.size()), 64'(0));
    run_cycle(0, 0, 0, 0, 0, 0);
    check("busy_rdstart_n", 64'(rs_cyc_q.size()), 64'(1));
    if (rs_cyc_q.size() > 0) check("busy_rdstart_cyc", 64'(rs_cyc_q[0]), 64'(cyc - 1));
    run_cycle(0, 0, 0, 0, 0, 1);
    check("busy_loaded", 64'(seed_loaded), 64'(1));

    // Abort together with beat 40.
    clear_logs();
    run_cycle(1, 0, 0, 0, 0, 0);
    feed(SW, 0, 40);
    repeat (4) run_cycle(0, 0, 1, 32'hdead_beef, 0, 0);
    check("abort_nwrites", 64'(wr_addr_q.size()), 64'(41));
    check("abort_order", 64'(bad_writes()), 64'(0));
    check("abort_loaded", 64'(seed_loaded), 64'(0));
    check("abort_rdstart", 64'(rs_cyc_q.size()), 64'(0));
    check("abort_ready", 64'(wr_ready), 64'(0));

    // Asynchronous reset at word 50, then a fresh load restarts at BASE.
    clear_logs();
    run_cycle(1, 0, 0, 0, 0, 0);
    feed(50, 0, -1);
    rst = 1'b1;
    #2;
    check("arst_ctrl", 64'({wr_ready, rd_start, ram_wren, seed_loaded, err_busy, ram_wraddr}), 64'(0));
    check("arst_wdata", 64'(ram_wdata), 64'(0));
    check("arst_xor", 64'(seed_xor), 64'(0));
    model_reset();
    @(posedge clk_in);
    #1;
    rst = 1'b0;
    clear_logs();
    run_cycle(1, 0, 0, 0, 0, 0);
    feed(1, 0, -1);
    run_cycle(0, 1, 0, 0, 0, 0);
    check("arst_restart_n", 64'(wr_addr_q.size()), 64'(1));
    if (wr_addr_q.size() > 0) check("arst_restart_addr", 64'(wr_addr_q[0]), 64'(BASE));

    // Random traffic against the model.
    busy = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(7) == 0) busy = !busy;
      run_cycle($urandom_range(39) == 0, $urandom_range(199) == 0,
                $urandom_range(9) < 7, $urandom, busy, $urandom_range(4) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
